// File: rtl/obi_pixel_mem.sv
// ---------------------------------------------------------------------------
// obi_pixel_mem
//
// OBI subordinate scratchpad holding pixel data for the image-processing
// accelerator and the core. It accepts one request at a time, commits writes
// with byte enables and returns the response exactly LATENCY cycles after the
// grant. Accesses outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS) complete with
// err = 1 and rdata = 0 and never touch the array.
//
// Parameters:
//   DATA_WIDTH   data bus width (only 32 is supported)
//   ADDR_WIDTH   address bus width
//   BASE_ADDR    byte address of word 0
//   DEPTH_WORDS  number of 32-bit words, power of two in 16..65536
//   LATENCY      cycles from handshake to rvalid, 1..15
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous, active-high reset
//   obi_req_i      request valid
//   obi_we_i       1 = write, 0 = read
//   obi_addr_i     byte address, bits [1:0] ignored
//   obi_be_i       byte enables (writes only)
//   obi_wdata_i    write data
//   obi_gnt_o      grant, combinational from obi_req_i
//   obi_rvalid_o   one-cycle response pulse
//   obi_rdata_o    read data, 0 for writes, errors and outside the response
//   obi_err_o      error flag, valid with obi_rvalid_o
//
// Build option:
//   OBI_PIXEL_MEM_STALL_EN  when defined, an 8-bit LFSR (x^8+x^6+x^5+x^4+1,
//                           seed 8'hA5) inserts random grant stalls for
//                           backpressure testing. Response latency is unchanged.
// ---------------------------------------------------------------------------
module obi_pixel_mem #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int unsigned           DEPTH_WORDS = 1024,
    parameter int unsigned           LATENCY     = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    obi_req_i,
    input  logic                    obi_we_i,
    input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
    input  logic [DATA_WIDTH/8-1:0] obi_be_i,
    input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
    output logic                    obi_gnt_o,
    output logic                    obi_rvalid_o,
    output logic [DATA_WIDTH-1:0]   obi_rdata_o,
    output logic                    obi_err_o
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned NUM_BE = DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = 4;
    // Counter preload: the WAIT state lasts LATENCY-1 cycles, counting down to 0.
    localparam logic [CNT_W-1:0] LAT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    rd_hit_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   mem_rdata_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH_WORDS];

    logic                    stall_ok;
    logic                    handshake;
    logic [ADDR_WIDTH-1:0]   offset;
    logic                    in_range;
    logic [IDX_W-1:0]        word_idx;
    logic [1:0]              unused_offset_lsb;

    // ------------------------------------------------------------------
    // Address decode. The subtraction wraps for addresses below the base,
    // so the lower bound is checked separately; the upper bound reduces to
    // "no offset bits above the word index" because the depth is a power
    // of two, which avoids overflow of BASE_ADDR + 4*DEPTH_WORDS.
    // ------------------------------------------------------------------
    assign offset            = obi_addr_i - BASE_ADDR;
    assign in_range          = (obi_addr_i >= BASE_ADDR) &&
                               (offset[ADDR_WIDTH-1:IDX_W+2] == '0);
    assign word_idx          = offset[IDX_W+1:2];
    assign unused_offset_lsb = offset[1:0];

`ifdef OBI_PIXEL_MEM_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
    assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign stall_ok = ~lfsr_q[0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign stall_ok = 1'b1;
`endif

    // Grant only when no response is outstanding or the outstanding one is
    // being delivered this cycle (back-to-back acceptance in RESP).
    assign obi_gnt_o = obi_req_i & ~rst_i & stall_ok & ((state_q == IDLE) || (state_q == RESP));
    assign handshake = obi_gnt_o;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (!handshake) begin
                    state_d = IDLE;
                end else if (LATENCY == 1) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    cnt_d   = LAT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rd_hit_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (handshake) begin
                rd_hit_q <= in_range & ~obi_we_i;
                err_q    <= ~in_range;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage array with byte-lane writes and a registered read port
    // ------------------------------------------------------------------
    // NOTE: the array and its read register have no reset; clearing a RAM
    // is neither required nor mappable onto block memories.
    always_ff @(posedge clk_i) begin
        if (handshake && in_range) begin
            if (obi_we_i) begin
                for (int b = 0; b < NUM_BE; b++) begin
                    if (obi_be_i[b]) begin
                        mem_q[word_idx][8*b +: 8] <= obi_wdata_i[8*b +: 8];
                    end
                end
            end else begin
                mem_rdata_q <= mem_q[word_idx];
            end
        end
    end

    // Gating with ~rst_i drops a response that is due in the reset cycle.
    assign obi_rvalid_o = (state_q == RESP) & ~rst_i;
    assign obi_err_o    = obi_rvalid_o & err_q;
    assign obi_rdata_o  = (obi_rvalid_o && rd_hit_q) ? mem_rdata_q : '0;

endmodule

// File: doc/obi_pixel_mem.md
# obi_pixel_mem

OBI subordinate scratchpad that serves the image-processing accelerator's OBI manager port as the source and destination of pixel data. It accepts one request at a time, commits writes with byte enables, and returns read data a fixed, parameterised number of cycles after grant. Out-of-range accesses complete with an error response. It sits on the user-domain interconnect next to the accelerator and is also reachable by the core for loading and inspecting frames.

## Interface
- `DATA_WIDTH`, 32: data bus width; only 32 is supported.
- `ADDR_WIDTH`, 32: address bus width.
- `BASE_ADDR`, 32'h0: byte address of word 0.
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, from 16 to 65536.
- `LATENCY`, 1: cycles from the handshake cycle to `rvalid`; 1..15.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `obi_req_i`  in  1  request valid.
- `obi_we_i`  in  1  1 = write, 0 = read.
- `obi_addr_i`  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- `obi_be_i`  in  4  byte enables, writes only.
- `obi_wdata_i`  in  32  write data.
- `obi_gnt_o`  out  1  grant.
- `obi_rvalid_o`  out  1  response valid, one-cycle pulse.
- `obi_rdata_o`  out  32  read data; 0 for writes and errors.
- `obi_err_o`  out  1  error flag, valid with `rvalid`.

## Operation
- Address decoding:
  - Word index: `(addr - BASE_ADDR) >> 2`.
  - In range iff `BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS`; the compare is unsigned at full ADDR_WIDTH.
- State machine, states IDLE, WAIT, RESP:
  - Handshake: `req & gnt` in the same cycle.
  - `gnt = req & ~rst_i & (state == IDLE | state == RESP)`. Grant is combinational from `req`.
  - IDLE on handshake:
    - LATENCY == 1: go to RESP.
    - LATENCY > 1: go to WAIT and load the latency counter with LATENCY-2.
  - WAIT: decrement the counter each cycle. At 0, go to RESP.
  - RESP: assert `rvalid`, `rdata`, `err` for exactly this cycle.
    - A new handshake in this cycle is accepted (back-to-back) and follows the same IDLE transition rules.
    - Otherwise return to IDLE.
- Actions at the handshake edge:
  - In-range write: each byte lane with `be[i] = 1` is written. `be = 0` writes nothing and still responds normally.
  - In-range read: `mem[index]` is sampled into the response register. A write committed in the previous handshake is visible.
  - Out of range: no write. Response has `err = 1`, `rdata = 0`.
- Response fields outside RESP: `rvalid = 0`, `rdata = 0`, `err = 0`.
- The manager has no `rready`; it must accept `rvalid` unconditionally.
- The memory array is not reset; its contents after reset are undefined.

## Timing
- Reset values: state IDLE, counter 0, `gnt = 0` while `rst_i` is high, `rvalid = 0`, `rdata = 0`, `err = 0`.
- Handshake in cycle N produces `rvalid` in cycle N+LATENCY.
- Sustained throughput:
  - 1 access per cycle at LATENCY = 1.
  - 1 access per LATENCY cycles otherwise.
- `req` deasserted while `gnt` is low is permitted; nothing is latched.
- Reset asserted in WAIT or RESP:
  - The pending response is dropped and no `rvalid` follows.
  - A write whose handshake edge preceded the reset edge stays committed.
- Request fields must be held stable while `req & ~gnt`. Only the values present in the handshake cycle are used.

## Configuration
- Macro: `OBI_PIXEL_MEM_STALL_EN`.
- Defined: random grant stalls are inserted for backpressure testing.
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset, advancing every cycle.
  - `gnt` is additionally gated by `lfsr[0] == 0`.
  - Latency after handshake is unchanged.
- Undefined: no LFSR logic and no stall; grant follows the rule above.

## Test plan
- Write then read: write 0xDEADBEEF with be 4'hF to BASE_ADDR+0x10, then read the same address → `rvalid` with rdata 0xDEADBEEF, err 0, exactly LATENCY cycles after each handshake.
- Byte enables: word preloaded with 0x11223344, write 0xAABBCCDD with be 4'b0101, read back → 0x11BB33DD.
- Out of range: read at BASE_ADDR+4*DEPTH_WORDS → err 1, rdata 0; a write to the same address is dropped, and word 0 and the last word are unchanged.
- Back-to-back at LATENCY=1: write A to addr X in cycle N, read addr X in cycle N+1 → both granted with no gap; the read returns A in cycle N+2.
- LATENCY=3: a second `req` issued one cycle after a handshake sees `gnt` low for 2 cycles and is granted in the RESP cycle; the two rvalids are 3 cycles apart.
- Reset mid-WAIT (LATENCY=4): pulse `rst_i` 2 cycles after a read handshake → no `rvalid` follows. A write granted before the reset reads back correctly afterwards.
